hb_cascade_sched: RTL and testbench
===================================

// Module: hb_cascade_sched
// PURPOSE
// Scheduler/controller in front of the IQ halfband decimation cascade (x2 h0 -> h1 -> h2).
// - Pairs a single-rate IQ stream into the (current, delayed) sample pairs the x2 first stage consumes.
// - Enforces a minimum issue spacing and gates off the cascade warm-up transient.
// - On stop, flushes the filter pipeline with zero pairs.
// PARAMETERS
// WIDTH        16   IQ sample width, two's complement
// SETTLE       32   cascade output samples discarded after each start
// FLUSH_PAIRS  64   zero pairs issued to the cascade on stop
// MIN_GAP      3    idle cycles forced after each pair issue (0 = back-to-back)
// CNT_W        32   width of output sample counter
// PORTS
// i_clock                i  1      clock
// i_reset_n              i  1      async active-low reset
// i_start                i  1      start pulse (honoured in IDLE only)
// i_stop                 i  1      stop pulse (honoured in RUN only)
// i_inph_data/i_quad_data i WIDTH  upstream IQ sample
// i_valid                i  1      upstream sample valid
// o_ready                o  1      upstream ready; transfer = i_valid & o_ready
// o_cas_inph_data/o_cas_quad_data             o WIDTH  newer sample of pair to cascade
// o_cas_inph_delay_data/o_cas_quad_delay_data o WIDTH  older sample of pair to cascade
// o_cas_valid            o  1      pair valid to cascade (1-cycle pulse)
// i_cas_inph_data/i_cas_quad_data i WIDTH  cascade output
// i_cas_valid            i  1      cascade output valid
// o_inph_data/o_quad_data o WIDTH  gated decimated output
// o_valid                o  1      gated output valid
// o_busy                 o  1      state != IDLE
// o_out_count            o  CNT_W  samples emitted on o_valid since last start, saturating
// BEHAVIOUR
// Reset (async, i_reset_n=0): state IDLE; every output, hold reg, phase, gap/settle/flush counters = 0.
// States: IDLE -> RUN on i_start; RUN -> FLUSH on i_stop; FLUSH -> IDLE after FLUSH_PAIRS issued.
// IDLE
// - o_ready=0; cascade outputs ignored.
// - i_start clears phase, gap, settle count and o_out_count; RUN from next cycle.
// RUN
// - o_ready = (gap_cnt==0), combinational from regs.
// - phase 0 transfer: sample -> hold regs, phase=1.
// - phase 1 transfer: next cycle o_cas_*_delay_data=hold, o_cas_*_data=sample, o_cas_valid=1; phase=0; gap_cnt=MIN_GAP.
// - gap_cnt decrements each cycle to 0, so pair issues are spaced >= MIN_GAP+1 cycles.
// - o_cas_* data holds last value when o_cas_valid=0.
// i_stop in RUN
// - A transfer in the same cycle completes normally; if it is a phase-1 transfer, its pair issues.
// - Then FLUSH; a pending phase-1 half-pair is discarded.
// - i_start ignored in RUN/FLUSH; i_stop ignored in IDLE/FLUSH.
// FLUSH
// - o_ready=0.
// - Issues FLUSH_PAIRS all-zero pairs, each honouring gap_cnt (first no earlier than gap_cnt==0).
// - IDLE the cycle after the last zero pair's o_cas_valid.
// Output gate (RUN and FLUSH)
// - While settle_cnt<SETTLE, each i_cas_valid increments settle_cnt and is dropped.
// - Afterwards i_cas_* is registered to o_*: o_valid 1 cycle after i_cas_valid, o_out_count+1.
// - o_out_count saturates at 2^CNT_W-1.
// - o_* data holds when o_valid=0.
// No backpressure from cascade or downstream; every i_cas_valid is handled in its cycle.
// TESTING
// 1 MIN_GAP=3: start, samples 1,2,3,4 valid every cycle -> o_cas delay=1/data=2 one cycle after 2 accepted; o_ready low 3 cycles; then delay=3/data=4.
// 2 SETTLE=2: cascade model pulses i_cas_valid with 10,11,12 -> only 12 appears on o_valid; o_out_count=1.
// 3 FLUSH_PAIRS=4: accept 5 only, pulse i_stop -> 5 never issued; 4 zero pairs spaced 4 cycles apart; then o_busy=0, o_ready=0.
// 4 i_stop in the cycle sample 6 completes a pair (hold=5) -> pair (5,6) issued, then 4 zero pairs.
// 5 Assert i_reset_n=0 mid-RUN with o_valid high -> all outputs 0 immediately (no clock edge); IDLE after release.
// 6 i_start during FLUSH -> ignored; i_start in IDLE with o_out_count=7 -> count 0 next cycle; CNT_W=3 run saturates at 7.

Source files
------------

// File: rtl/hb_cascade_sched_if.sv
// hb_cascade_sched_if: upstream, cascade and gated-output signals of the halfband cascade scheduler
interface hb_cascade_sched_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
);
  logic             i_start;
  logic             i_stop;
  logic [WIDTH-1:0] i_inph_data;
  logic [WIDTH-1:0] i_quad_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_cas_inph_data;
  logic [WIDTH-1:0] o_cas_quad_data;
  logic [WIDTH-1:0] o_cas_inph_delay_data;
  logic [WIDTH-1:0] o_cas_quad_delay_data;
  logic             o_cas_valid;
  logic [WIDTH-1:0] i_cas_inph_data;
  logic [WIDTH-1:0] i_cas_quad_data;
  logic             i_cas_valid;
  logic [WIDTH-1:0] o_inph_data;
  logic [WIDTH-1:0] o_quad_data;
  logic             o_valid;
  logic             o_busy;
  logic [CNT_W-1:0] o_out_count;
  modport slave (
    input  i_start, i_stop, i_inph_data, i_quad_data, i_valid,
           i_cas_inph_data, i_cas_quad_data, i_cas_valid,
    output o_ready, o_cas_inph_data, o_cas_quad_data, o_cas_inph_delay_data,
           o_cas_quad_delay_data, o_cas_valid, o_inph_data, o_quad_data,
           o_valid, o_busy, o_out_count
  );
  modport master (
    output i_start, i_stop, i_inph_data, i_quad_data, i_valid,
           i_cas_inph_data, i_cas_quad_data, i_cas_valid,
    input  o_ready, o_cas_inph_data, o_cas_quad_data, o_cas_inph_delay_data,
           o_cas_quad_delay_data, o_cas_valid, o_inph_data, o_quad_data,
           o_valid, o_busy, o_out_count
  );
endinterface

// File: rtl/hb_cascade_sched.sv
// hb_cascade_sched: pairs IQ samples for the x2 halfband cascade, spaces issues,
// drops the warm-up transient and flushes the cascade with zero pairs on stop
module hb_cascade_sched #(
  parameter int WIDTH       = 16,
  parameter int SETTLE      = 32,
  parameter int FLUSH_PAIRS = 64,
  parameter int MIN_GAP     = 3,
  parameter int CNT_W       = 32
) (
  input logic               i_clock,
  input logic               i_reset_n,
  hb_cascade_sched_if.slave bus
);
  localparam int GW = $clog2(MIN_GAP + 2);
  localparam int SW = $clog2(SETTLE + 2);
  localparam int FW = $clog2(FLUSH_PAIRS + 2);
  localparam logic [GW-1:0] GAP_C    = GW'(MIN_GAP);
  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
  localparam logic [FW-1:0] FLUSH_C  = FW'(FLUSH_PAIRS);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [WIDTH-1:0] hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic [WIDTH-1:0] ci_q, ci_d, cq_q, cq_d, cdi_q, cdi_d, cdq_q, cdq_d;
  logic             cv_q, cv_d;
  logic [WIDTH-1:0] oi_q, oi_d, oq_q, oq_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready, xfer;
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    gap_d    = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    settle_d = settle_q;
    flush_d  = flush_q;
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    ci_d     = ci_q;
    cq_d     = cq_q;
    cdi_d    = cdi_q;
    cdq_d    = cdq_q;
    cv_d     = 1'b0;
    oi_d     = oi_q;
    oq_d     = oq_q;
    ov_d     = 1'b0;
    cnt_d    = cnt_q;
    ready    = (state_q == RUN) && (gap_q == '0);
    xfer     = ready && bus.i_valid;
    if (state_q == IDLE && bus.i_start) begin
      state_d  = RUN;
      phase_d  = 1'b0;
      gap_d    = '0;
      settle_d = '0;
      flush_d  = '0;
      cnt_d    = '0;
    end
    if (xfer && !phase_q) begin
      hold_i_d = bus.i_inph_data;
      hold_q_d = bus.i_quad_data;
      phase_d  = 1'b1;
    end
    if (xfer && phase_q) begin
      ci_d    = bus.i_inph_data;
      cq_d    = bus.i_quad_data;
      cdi_d   = hold_i_q;
      cdq_d   = hold_q_q;
      cv_d    = 1'b1;
      phase_d = 1'b0;
      gap_d   = GAP_C;
    end
    // a half-pair still waiting for its partner is abandoned on stop
    if (state_q == RUN && bus.i_stop) begin
      state_d = FLUSH;
      phase_d = 1'b0;
    end
    if (state_q == FLUSH && flush_q == FLUSH_C) state_d = IDLE;
    if (state_q == FLUSH && flush_q != FLUSH_C && gap_q == '0) begin
      ci_d    = '0;
      cq_d    = '0;
      cdi_d   = '0;
      cdq_d   = '0;
      cv_d    = 1'b1;
      gap_d   = GAP_C;
      flush_d = flush_q + 1'b1;
    end
    if (state_q != IDLE && bus.i_cas_valid && settle_q < SETTLE_C) settle_d = settle_q + 1'b1;
    if (state_q != IDLE && bus.i_cas_valid && settle_q >= SETTLE_C) begin
      oi_d  = bus.i_cas_inph_data;
      oq_d  = bus.i_cas_quad_data;
      ov_d  = 1'b1;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      gap_q    <= '0;
      settle_q <= '0;
      flush_q  <= '0;
      hold_i_q <= '0;
      hold_q_q <= '0;
      ci_q     <= '0;
      cq_q     <= '0;
      cdi_q    <= '0;
      cdq_q    <= '0;
      cv_q     <= 1'b0;
      oi_q     <= '0;
      oq_q     <= '0;
      ov_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
      flush_q  <= flush_d;
      hold_i_q <= hold_i_d;
      hold_q_q <= hold_q_d;
      ci_q     <= ci_d;
      cq_q     <= cq_d;
      cdi_q    <= cdi_d;
      cdq_q    <= cdq_d;
      cv_q     <= cv_d;
      oi_q     <= oi_d;
      oq_q     <= oq_d;
      ov_q     <= ov_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.o_ready               = ready;
  assign bus.o_cas_inph_data       = ci_q;
  assign bus.o_cas_quad_data       = cq_q;
  assign bus.o_cas_inph_delay_data = cdi_q;
  assign bus.o_cas_quad_delay_data = cdq_q;
  assign bus.o_cas_valid           = cv_q;
  assign bus.o_inph_data           = oi_q;
  assign bus.o_quad_data           = oq_q;
  assign bus.o_valid               = ov_q;
  assign bus.o_busy                = (state_q != IDLE);
  assign bus.o_out_count           = cnt_q;
endmodule

// File: tb/tb_hb_cascade_sched.sv
// tb_hb_cascade_sched: directed checks of pairing, spacing, settle gate, flush, reset and count saturation
module tb_hb_cascade_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  hb_cascade_sched_if #(.WIDTH(16), .CNT_W(3)) bus ();
  hb_cascade_sched #(
    .WIDTH(16), .SETTLE(2), .FLUSH_PAIRS(4), .MIN_GAP(3), .CNT_W(3)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic flush_check(input int first, input bit poke);
    for (int p = 0; p < 4; p++) begin
      for (int j = 1; j <= ((p == 0) ? first : 4); j++) begin
        if (poke && p == 1 && j == 1) bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        if (j < ((p == 0) ? first : 4)) chk("flush_gap", {31'd0, bus.o_cas_valid}, 0);
      end
      chk("flush_v", {31'd0, bus.o_cas_valid}, 1);
      chk("flush_dat", {bus.o_cas_inph_data, bus.o_cas_quad_data}, 0);
      chk("flush_dly", {bus.o_cas_inph_delay_data, bus.o_cas_quad_delay_data}, 0);
      chk("flush_busy", {31'd0, bus.o_busy}, 1);
    end
    step();
    chk("flush_idle", {31'd0, bus.o_busy}, 0);
    chk("flush_rdy", {31'd0, bus.o_ready}, 0);
    chk("flush_cv", {31'd0, bus.o_cas_valid}, 0);
  endtask
  task automatic put(input int v);
    bus.i_valid = 1'b1;
    bus.i_inph_data = 16'(v);
    bus.i_quad_data = 16'(100 + v);
  endtask
  task automatic cas(input int v);
    bus.i_cas_valid = 1'b1;
    bus.i_cas_inph_data = 16'(v);
    bus.i_cas_quad_data = 16'(200 + v);
  endtask
  initial begin
    bus.i_start = 0; bus.i_stop = 0; bus.i_valid = 0;
    bus.i_inph_data = 0; bus.i_quad_data = 0;
    bus.i_cas_valid = 0; bus.i_cas_inph_data = 0; bus.i_cas_quad_data = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'd0, bus.o_ready}, 0);
    chk("rst_busy", {31'd0, bus.o_busy}, 0);
    chk("rst_cv", {31'd0, bus.o_cas_valid}, 0);
    chk("rst_ov", {31'd0, bus.o_valid}, 0);
    chk("rst_cnt", {29'd0, bus.o_out_count}, 0);
    chk("rst_cdat", {bus.o_cas_inph_data, bus.o_cas_inph_delay_data}, 0);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    chk("stop_idle", {31'd0, bus.o_busy}, 0);
    cas(9);
    step();
    bus.i_cas_valid = 1'b0;
    chk("idle_cas_ign", {31'd0, bus.o_valid}, 0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk("t1_busy", {31'd0, bus.o_busy}, 1);
    chk("t1_ready", {31'd0, bus.o_ready}, 1);
    put(1);
    step();
    chk("t1_half", {31'd0, bus.o_cas_valid}, 0);
    put(2);
    step();
    put(3);
    chk("t1_cv1", {31'd0, bus.o_cas_valid}, 1);
    chk("t1_p1_i", {bus.o_cas_inph_delay_data, bus.o_cas_inph_data}, 32'h0001_0002);
    chk("t1_p1_q", {bus.o_cas_quad_delay_data, bus.o_cas_quad_data}, {16'd101, 16'd102});
    chk("t1_gap0", {31'd0, bus.o_ready}, 0);
    step();
    chk("t1_gap1", {31'd0, bus.o_ready}, 0);
    chk("t1_hold", {31'd0, bus.o_cas_valid}, 0);
    chk("t1_hold_d", {16'd0, bus.o_cas_inph_data}, 2);
    step();
    chk("t1_gap2", {31'd0, bus.o_ready}, 0);
    step();
    chk("t1_gap3", {31'd0, bus.o_ready}, 1);
    step();
    put(4);
    chk("t1_half2", {31'd0, bus.o_cas_valid}, 0);
    step();
    bus.i_valid = 1'b0;
    chk("t1_cv2", {31'd0, bus.o_cas_valid}, 1);
    chk("t1_p2_i", {bus.o_cas_inph_delay_data, bus.o_cas_inph_data}, 32'h0003_0004);
    cas(10);
    step();
    chk("t2_drop10", {31'd0, bus.o_valid}, 0);
    bus.i_cas_valid = 1'b0;
    step();
    cas(11);
    step();
    chk("t2_drop11", {31'd0, bus.o_valid}, 0);
    cas(12);
    step();
    bus.i_cas_valid = 1'b0;
    chk("t2_ov", {31'd0, bus.o_valid}, 1);
    chk("t2_dat", {bus.o_inph_data, bus.o_quad_data}, {16'd12, 16'd212});
    chk("t2_cnt", {29'd0, bus.o_out_count}, 1);
    step();
    chk("t2_ov_low", {31'd0, bus.o_valid}, 0);
    chk("t2_hold", {16'd0, bus.o_inph_data}, 12);
    put(5);
    step();
    bus.i_valid = 1'b0;
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    chk("t3_rdy", {31'd0, bus.o_ready}, 0);
    chk("t3_busy", {31'd0, bus.o_busy}, 1);
    chk("t3_no5", {31'd0, bus.o_cas_valid}, 0);
    flush_check(1, 1'b0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk("t4_cnt_clr", {29'd0, bus.o_out_count}, 0);
    put(5);
    step();
    put(6);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    bus.i_valid = 1'b0;
    chk("t4_cv", {31'd0, bus.o_cas_valid}, 1);
    chk("t4_pair", {bus.o_cas_inph_delay_data, bus.o_cas_inph_data}, 32'h0005_0006);
    chk("t4_busy", {31'd0, bus.o_busy}, 1);
    flush_check(4, 1'b0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      cas(k);
      step();
      chk("t6_ov", {31'd0, bus.o_valid}, (k >= 2) ? 1 : 0);
      chk("t6_cnt", {29'd0, bus.o_out_count}, (k < 2) ? 0 : ((k - 1 > 7) ? 7 : k - 1));
    end
    chk("t6_last", {16'd0, bus.o_inph_data}, 10);
    bus.i_cas_valid = 1'b0;
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    flush_check(1, 1'b1);
    chk("t6_sat", {29'd0, bus.o_out_count}, 7);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk("t6_clr", {29'd0, bus.o_out_count}, 0);
    chk("t6_busy", {31'd0, bus.o_busy}, 1);
    put(7);
    step();
    put(8);
    step();
    bus.i_valid = 1'b0;
    chk("t5_pair", {bus.o_cas_inph_delay_data, bus.o_cas_inph_data}, 32'h0007_0008);
    for (int k = 0; k < 3; k++) begin
      cas(20 + k);
      step();
    end
    bus.i_cas_valid = 1'b0;
    chk("t5_ov_hi", {31'd0, bus.o_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ov", {31'd0, bus.o_valid}, 0);
    chk("t5_odat", {bus.o_inph_data, bus.o_quad_data}, 0);
    chk("t5_cdat", {bus.o_cas_inph_data, bus.o_cas_inph_delay_data}, 0);
    chk("t5_cv", {31'd0, bus.o_cas_valid}, 0);
    chk("t5_cnt", {29'd0, bus.o_out_count}, 0);
    chk("t5_busy", {31'd0, bus.o_busy}, 0);
    chk("t5_rdy", {31'd0, bus.o_ready}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_idle", {31'd0, bus.o_busy}, 0);
    chk("t5_idle_rdy", {31'd0, bus.o_ready}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
